imem_loader: RTL

//   Byte-stream program loader for the single-cycle CPU: receives a framed byte

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the single-cycle CPU.
// Frame = SYNC_BYTE, 16-bit big-endian word count, then 4 bytes per word
// (MSB first). Each assembled word is written with a one-cycle im_we strobe.
// The CPU is held in reset until the whole frame has been written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] MAX_LEN = 16'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [23:0] shift_q, shift_d;      // first three bytes of the word in flight
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] words_q, words_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        in_ready_q, in_ready_d;
  logic        we_q, we_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] len_full;

  // A byte moves only when the loader advertised readiness this cycle.
  assign accept   = in_valid && in_ready_q;
  assign len_full = {len_hi_q, in_data};

  // Next-state and next-output computation for the framing FSM.
  always_comb begin
    // NOTE: every _d defaults to its _q so no path through this block can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    words_d     = words_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_full;
          byte_cnt_d = 2'd0;
          if (len_full == 16'd0)        state_d = S_DONE;
          else if (len_full > MAX_LEN)  state_d = S_ERR;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;   // wraps to 0 after the 4th byte
          shift_d    = {shift_q[15:0], in_data};
          if (byte_cnt_q == 2'd3) begin
            wdata_d = {shift_q, in_data};
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        if (words_q + 16'd1 == len_q) state_d = S_DONE;
        else                          state_d = S_DATA;
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_IDLE;
    endcase

    // Sticky status follows the state being entered so it is visible
    // in the first cycle spent in DONE/ERR.
    if (state_d == S_DONE) begin
      done_d      = 1'b1;
      cpu_rst_n_d = 1'b1;
    end
    if (state_d == S_ERR) err_d = 1'b1;

    we_d       = (state_d == S_WRITE);
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LEN_HI) ||
                 (state_d == S_LEN_LO) || (state_d == S_DATA);
    busy_d     = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA) || (state_d == S_WRITE);
  end

  // State and registered outputs; async reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= 16'd0;
      shift_q     <= 24'd0;
      byte_cnt_q  <= 2'd0;
      words_q     <= 16'd0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      in_ready_q  <= 1'b1;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
